// File: rtl/multicycle_control_if.sv
// Purpose : control/handshake bundle between the multicycle controller and its datapath.
// Latency : n/a (wires only).
// Backpressure: memReady from memory stalls the controller in its memory states.
// Ports (master = controller side):
//   in : opcode[5:0] (IR[31:26]), memReady
//   out: pcWrite, irWrite, memRead, memWrite, regWrite, branchEq, branchNe,
//        iorD, regDst, memToReg, aluSrcA, aluSrcB[1:0], aluOp[1:0],
//        pcSource[1:0], state[3:0], illegal
interface multicycle_control_if;
    logic [5:0] opcode;
    logic       memReady;

    logic       pcWrite;
    logic       irWrite;
    logic       memRead;
    logic       memWrite;
    logic       regWrite;
    logic       branchEq;
    logic       branchNe;

    logic       iorD;
    logic       regDst;
    logic       memToReg;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic [1:0] pcSource;

    logic [3:0] state;
    logic       illegal;

    modport master (
        input  opcode, memReady,
        output pcWrite, irWrite, memRead, memWrite, regWrite, branchEq, branchNe,
               iorD, regDst, memToReg, aluSrcA, aluSrcB, aluOp, pcSource,
               state, illegal
    );

    modport slave (
        output opcode, memReady,
        input  pcWrite, irWrite, memRead, memWrite, regWrite, branchEq, branchNe,
               iorD, regDst, memToReg, aluSrcA, aluSrcB, aluOp, pcSource,
               state, illegal
    );
endinterface

// File: rtl/multicycle_control.sv
// Purpose : Moore FSM sequencing a MIPS-style multicycle datapath (lw/sw/R/beq/bne/j/addi).
// Latency : lw 5, sw/R/addi 4, beq/bne/j 3 cycles; each memory stall cycle adds one.
// Backpressure: memReady=0 holds FETCH/MEM_READ/MEM_WRITE with only memRead/memWrite asserted.
// Ports   : clock, reset (sync, active-high); bus = multicycle_control_if.master
//           (opcode/memReady in; datapath strobes, mux selects, debug state, sticky illegal out).
module multicycle_control (
    input  logic                  clock,
    input  logic                  reset,
    multicycle_control_if.master  bus
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_HALT      = 4'd12
    } state_t;

    // State-only controls, registered alongside the state so outputs come straight from flops.
    typedef struct packed {
        logic       pc_write;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       branch_eq;
        logic       branch_ne;
        logic       ior_d;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // Output decode of a state. The opcode only matters for BRANCH; it is taken from the
    // cycle that enters BRANCH (DECODE), where the IR already holds the same instruction.
    function automatic ctrl_t decode_ctrl(input state_t s, input logic [5:0] op);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = 2'b01;
            end
            S_DECODE:    c.alu_src_b = 2'b11;
            S_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_MEM_READ: begin
                c.mem_read = 1'b1;
                c.ior_d    = 1'b1;
            end
            S_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                c.mem_write = 1'b1;
                c.ior_d     = 1'b1;
            end
            S_R_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b10;
            end
            S_R_WB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b01;
                c.pc_source = 2'b01;
                c.branch_eq = (op == OP_BEQ);
                c.branch_ne = (op == OP_BNE);
            end
            S_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b10;
            end
            S_ADDI_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_ADDI_WB:   c.reg_write = 1'b1;
            default:     c = '0;
        endcase
        return c;
    endfunction

    state_t state_q, state_d;
    ctrl_t  ctrl_q,  ctrl_d;
    logic   illegal_q, illegal_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:     if (bus.memReady) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW:   state_d = S_MEM_ADDR;
                    OP_RTYPE:       state_d = S_R_EXEC;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_J:           state_d = S_JUMP;
                    OP_ADDI:        state_d = S_ADDI_EXEC;
                    default:        state_d = S_HALT;
                endcase
            end
            S_MEM_ADDR:  state_d = (bus.opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  if (bus.memReady) state_d = S_MEM_WB;
            S_MEM_WRITE: if (bus.memReady) state_d = S_FETCH;
            S_R_EXEC:    state_d = S_R_WB;
            S_ADDI_EXEC: state_d = S_ADDI_WB;
            S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB:
                         state_d = S_FETCH;
            S_HALT:      state_d = S_HALT;
            // Encodings 13-15 are unreachable; recover into HALT and flag it.
            default:     state_d = S_HALT;
        endcase

        ctrl_d    = decode_ctrl(state_d, bus.opcode);
        illegal_d = illegal_q | (state_d == S_HALT);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_FETCH;
            ctrl_q    <= decode_ctrl(S_FETCH, 6'b000000);
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            illegal_q <= illegal_d;
        end
    end

    // While reset is held the datapath sees FETCH controls immediately, whatever state
    // the flops still hold, and the memReady-qualified fetch strobes stay off.
    ctrl_t ctrl_out;
    logic  fetch_fire;

    always_comb begin
        ctrl_out   = reset ? decode_ctrl(S_FETCH, 6'b000000) : ctrl_q;
        fetch_fire = (state_q == S_FETCH) && bus.memReady && !reset;
    end

    assign bus.irWrite  = fetch_fire;
    assign bus.pcWrite  = ctrl_out.pc_write | fetch_fire;
    assign bus.memRead  = ctrl_out.mem_read;
    assign bus.memWrite = ctrl_out.mem_write;
    assign bus.regWrite = ctrl_out.reg_write;
    assign bus.branchEq = ctrl_out.branch_eq;
    assign bus.branchNe = ctrl_out.branch_ne;
    assign bus.iorD     = ctrl_out.ior_d;
    assign bus.regDst   = ctrl_out.reg_dst;
    assign bus.memToReg = ctrl_out.mem_to_reg;
    assign bus.aluSrcA  = ctrl_out.alu_src_a;
    assign bus.aluSrcB  = ctrl_out.alu_src_b;
    assign bus.aluOp    = ctrl_out.alu_op;
    assign bus.pcSource = ctrl_out.pc_source;
    assign bus.state    = state_q;
    assign bus.illegal  = illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Purpose : randomized check of multicycle_control against an instruction-level model.
// Latency : model tracks per-instruction state paths and total cycle counts.
// Backpressure: memReady stalls scripted/randomized per memory state.
module tb_multicycle_control;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    multicycle_control_if bus();

    multicycle_control dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at t=%0t: got=0x%0h expected=0x%0h", tag, $time, got, exp);
        end
    endtask

    typedef struct {
        logic [5:0] op;
        int         fstall;   // FETCH cycles with memReady low
        int         mstall;   // MEM_READ/MEM_WRITE cycles with memReady low
        int         halt;     // cycles to sit in HALT before reset
    } step_t;

    localparam int SCRIPT_N = 9;
    step_t       script [SCRIPT_N];
    logic [5:0]  op_tab [16];

    // Model state
    step_t cur;
    int    path[$];
    int    pos, st, stall_left, halt_left, inst_cycles, sidx;
    bit    model_illegal;

    // Expected cycles per instruction with memory always ready.
    function automatic int base_latency(input logic [5:0] op);
        case (op)
            6'h23:                  return 5;
            6'h2b, 6'h00, 6'h08:    return 4;
            6'h04, 6'h05, 6'h02:    return 3;
            default:                return 0;
        endcase
    endfunction

    function automatic bit is_mem_op(input logic [5:0] op);
        return (op == 6'h23) || (op == 6'h2b);
    endfunction

    // {pcWrite, irWrite, memRead, memWrite, regWrite, branchEq, branchNe}
    function automatic logic [6:0] exp_strobes(input int st_in, input logic [5:0] op,
                                               input logic mr, input logic rst);
        int s;
        bit fire;
        s    = rst ? 0 : st_in;
        fire = (s == 0) && mr && !rst;
        return {(s == 9) || fire, fire, (s == 0) || (s == 3), s == 5,
                s inside {4, 7, 11}, (s == 8) && (op == 6'h04), (s == 8) && (op == 6'h05)};
    endfunction

    // {iorD, regDst, memToReg, aluSrcA, aluSrcB, aluOp, pcSource}
    function automatic logic [9:0] exp_muxes(input int st_in, input logic rst);
        int s;
        logic [1:0] srcb, aop, psrc;
        s    = rst ? 0 : st_in;
        srcb = (s == 0) ? 2'd1 : (s == 1) ? 2'd3 : (s inside {2, 10}) ? 2'd2 : 2'd0;
        aop  = (s == 6) ? 2'd2 : (s == 8) ? 2'd1 : 2'd0;
        psrc = (s == 8) ? 2'd1 : (s == 9) ? 2'd2 : 2'd0;
        return {s inside {3, 5}, s == 7, s == 4, s inside {2, 6, 8, 10}, srcb, aop, psrc};
    endfunction

    task automatic start_instr();
        if (sidx < SCRIPT_N) begin
            cur = script[sidx];
        end else begin
            cur.op     = op_tab[$urandom_range(0, 15)];
            cur.fstall = $urandom_range(0, 3);
            cur.mstall = $urandom_range(0, 3);
            cur.halt   = $urandom_range(1, 6);
        end
        sidx++;
        case (cur.op)
            6'h23:          path = '{0, 1, 2, 3, 4};
            6'h2b:          path = '{0, 1, 2, 5};
            6'h00:          path = '{0, 1, 6, 7};
            6'h04, 6'h05:   path = '{0, 1, 8};
            6'h02:          path = '{0, 1, 9};
            6'h08:          path = '{0, 1, 10, 11};
            default:        path = '{0, 1, 12};
        endcase
        pos         = 0;
        st          = 0;
        stall_left  = cur.fstall;
        inst_cycles = 0;
    endtask

    initial begin
        logic       rst_v, mr;
        logic [5:0] op_v;
        bit         mem_st;
        int         exp_lat;

        script[0] = '{6'h23, 0, 0, 0};   // lw, no stalls
        script[1] = '{6'h2b, 0, 3, 0};   // sw, 3 stall cycles in MEM_WRITE
        script[2] = '{6'h05, 0, 0, 0};   // bne
        script[3] = '{6'h00, 0, 0, 0};   // R-type
        script[4] = '{6'h04, 2, 0, 0};   // beq after 2 FETCH stalls
        script[5] = '{6'h08, 0, 0, 0};   // addi
        script[6] = '{6'h02, 1, 0, 0};   // j
        script[7] = '{6'h23, 0, 2, 0};   // lw, 2 stalls in MEM_READ
        script[8] = '{6'h3f, 0, 0, 10};  // illegal, 10 cycles in HALT

        op_tab = '{6'h23, 6'h23, 6'h2b, 6'h2b, 6'h00, 6'h00, 6'h04, 6'h05,
                   6'h02, 6'h08, 6'h08, 6'h3f, 6'h23, 6'h00, 6'h01, 6'h2b};

        sidx          = 0;
        st            = 0;
        pos           = 0;
        stall_left    = 0;
        halt_left     = 0;
        inst_cycles   = 0;
        model_illegal = 1'b0;
        cur           = '{6'h00, 0, 0, 0};
        path          = '{0};

        reset        = 1'b1;
        bus.memReady = 1'b1;
        bus.opcode   = 6'h00;
        repeat (2) @(posedge clock);

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clock);

            // Inputs for this cycle, sampled at the next rising edge.
            rst_v = (cyc == 0);
            if (st == 12 && halt_left == 0) rst_v = 1'b1;
            if (sidx > SCRIPT_N && $urandom_range(0, 39) == 0) rst_v = 1'b1;
            mem_st = (st == 0) || (st == 3) || (st == 5);
            mr     = mem_st ? (stall_left == 0) : 1'($urandom_range(0, 1));
            if (st == 0)       op_v = (mr && !rst_v) ? cur.op : 6'($urandom);
            else if (st == 12) op_v = 6'($urandom);
            else               op_v = cur.op;

            reset        = rst_v;
            bus.memReady = mr;
            bus.opcode   = op_v;
            #1;

            check_eq("state",   32'(bus.state), 32'(st));
            check_eq("illegal", 32'(bus.illegal), 32'(model_illegal));
            check_eq("strobes", 32'({bus.pcWrite, bus.irWrite, bus.memRead, bus.memWrite,
                                     bus.regWrite, bus.branchEq, bus.branchNe}),
                     32'(exp_strobes(st, cur.op, mr, rst_v)));
            check_eq("muxes",   32'({bus.iorD, bus.regDst, bus.memToReg, bus.aluSrcA,
                                     bus.aluSrcB, bus.aluOp, bus.pcSource}),
                     32'(exp_muxes(st, rst_v)));

            // Advance the model across the coming edge.
            inst_cycles++;
            if (rst_v) begin
                model_illegal = 1'b0;
                start_instr();
            end else if (mem_st && !mr) begin
                stall_left--;
            end else if (st == 12) begin
                halt_left--;
            end else begin
                pos++;
                if (pos == path.size()) begin
                    exp_lat = base_latency(cur.op) + cur.fstall + (is_mem_op(cur.op) ? cur.mstall : 0);
                    check_eq("latency", 32'(inst_cycles), 32'(exp_lat));
                    start_instr();
                end else begin
                    st = path[pos];
                    if (st == 3 || st == 5) stall_left = cur.mstall;
                    if (st == 12) begin
                        model_illegal = 1'b1;
                        halt_left     = cur.halt;
                    end
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
